// File: rtl/load_store_unit.sv
// load_store_unit: CPU load/store front end for a single-port word-addressed data memory.
//
// A request is accepted in IDLE, then walks a small FSM: IDLE -> RD -> RESP for loads,
// IDLE -> WR -> RESP for word stores, IDLE -> RD -> WR -> RESP for subword stores
// (read-modify-write), and IDLE -> RESP for rejected requests.
//
// Configuration macro: LSU_SUBWORD_EN -- when defined, byte and half accesses are supported;
// when undefined, any byte/half request is rejected as an error.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/req_ready CPU request handshake (ready only in IDLE)
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 reserved
//   req_signed          sign-extend subword loads
//   req_addr            byte address
//   req_wdata           store data, right-aligned
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           load result (0 for stores and errors), held until next response
//   rsp_error           misaligned / out-of-range / reserved-size request
//   Address             word index to memory
//   writeenable         memory write strobe (sampled by memory on posedge)
//   readenable          memory read strobe (memory drives outdata on negedge)
//   writedata           memory write word
//   outdata             memory read word
module load_store_unit #(
    parameter int unsigned MEM_AW = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] Address,
    output logic        writeenable,
    output logic        readenable,
    output logic [31:0] writedata,
    input  logic [31:0] outdata
);

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    state_e      state_q, state_d;

    // Latched request fields
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;

    // Registered outputs
    logic [31:0] address_q, address_d;
    logic [31:0] wmem_q, wmem_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;
    logic        rvalid_q;
    logic        re_q;
    logic        we_q;

    // Request decode
    logic        out_of_range;
    logic        misaligned;
    logic        bad_size;
    logic        req_err;
    logic [31:0] word_idx;

    assign out_of_range = (req_addr >> (MEM_AW + 2)) != 32'd0;
    assign misaligned   = ((req_size == SzHalf) && req_addr[0]) ||
                          ((req_size == SzWord) && (req_addr[1:0] != 2'b00));
`ifdef LSU_SUBWORD_EN
    assign bad_size     = (req_size == 2'b11);
`else
    assign bad_size     = (req_size != SzWord);
`endif
    assign req_err      = out_of_range || misaligned || bad_size;
    assign word_idx     = {{(32 - MEM_AW){1'b0}}, req_addr[MEM_AW+1:2]};

    // Load extraction and store merge operate on the word sampled while leaving RD
    logic [31:0] load_data;
`ifdef LSU_SUBWORD_EN
    logic [4:0]  lane_sh;
    logic [31:0] lane_mask;
    logic [31:0] lane_word;
    logic [31:0] store_merge;

    always_comb begin
        lane_sh   = (size_q == SzHalf) ? {off_q[1], 4'b0000} : {off_q, 3'b000};
        lane_mask = (size_q == SzHalf) ? 32'h0000_FFFF : 32'h0000_00FF;
        lane_word = outdata >> lane_sh;
        case (size_q)
            SzByte:  load_data = {{24{signed_q & lane_word[7]}}, lane_word[7:0]};
            SzHalf:  load_data = {{16{signed_q & lane_word[15]}}, lane_word[15:0]};
            default: load_data = outdata;
        endcase
        store_merge = (outdata & ~(lane_mask << lane_sh)) | ((wdata_q & lane_mask) << lane_sh);
    end
`else
    assign load_data = outdata;

    logic unused_fields;
    assign unused_fields = ^{write_q, size_q, signed_q, off_q, wdata_q};
`endif

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        size_d    = size_q;
        signed_d  = signed_q;
        off_d     = off_q;
        wdata_d   = wdata_q;
        address_d = address_q;
        wmem_d    = wmem_q;
        rdata_d   = rdata_q;
        error_d   = error_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d   = req_write;
                    size_d    = req_size;
                    signed_d  = req_signed;
                    off_d     = req_addr[1:0];
                    wdata_d   = req_wdata;
                    address_d = word_idx;
                    if (req_err) begin
                        state_d = StResp;
                        rdata_d = 32'd0;
                        error_d = 1'b1;
                    end else if (req_write && (req_size == SzWord)) begin
                        state_d = StWr;
                        wmem_d  = req_wdata;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
`ifdef LSU_SUBWORD_EN
                if (write_q) begin
                    state_d = StWr;
                    wmem_d  = store_merge;
                end else begin
                    state_d = StResp;
                    rdata_d = load_data;
                    error_d = 1'b0;
                end
`else
                state_d = StResp;
                rdata_d = load_data;
                error_d = 1'b0;
`endif
            end
            StWr: begin
                state_d = StResp;
                rdata_d = 32'd0;
                error_d = 1'b0;
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes are derived from the next state so they are clean registered levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q   <= 1'b0;
            size_q    <= 2'b00;
            signed_q  <= 1'b0;
            off_q     <= 2'b00;
            wdata_q   <= 32'd0;
            address_q <= 32'd0;
            wmem_q    <= 32'd0;
            rdata_q   <= 32'd0;
            error_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            write_q   <= write_d;
            size_q    <= size_d;
            signed_q  <= signed_d;
            off_q     <= off_d;
            wdata_q   <= wdata_d;
            address_q <= address_d;
            wmem_q    <= wmem_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
            rvalid_q  <= (state_d == StResp);
            re_q      <= (state_d == StRd);
            we_q      <= (state_d == StWr);
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign rsp_valid   = rvalid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_error   = error_q;
    assign Address     = address_q;
    assign writeenable = we_q;
    assign readenable  = re_q;
    assign writedata   = wmem_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit with an attached word memory.
// Honours LSU_SUBWORD_EN the same way as the design.
module tb_load_store_unit;

    localparam int unsigned MEM_AW    = 8;
    localparam int unsigned MEM_WORDS = 1 << MEM_AW;
    localparam int unsigned MEM_BYTES = 4 * MEM_WORDS;
`ifdef LSU_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] Address;
    logic        writeenable;
    logic        readenable;
    logic [31:0] writedata;
    logic [31:0] outdata;

    logic [31:0] mem [0:MEM_WORDS-1];
    logic [7:0]  shadow [0:MEM_BYTES-1];

    int total = 0;
    int bad   = 0;

    load_store_unit #(.MEM_AW(MEM_AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .Address     (Address),
        .writeenable (writeenable),
        .readenable  (readenable),
        .writedata   (writedata),
        .outdata     (outdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory: write on posedge, read data appears on negedge
    always @(posedge clk) if (writeenable) mem[Address[MEM_AW-1:0]] <= writedata;
    always @(negedge clk) if (readenable) outdata <= mem[Address[MEM_AW-1:0]];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic void check(input string nm, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] shadow_word(input int idx);
        return {shadow[4*idx+3], shadow[4*idx+2], shadow[4*idx+1], shadow[4*idx]};
    endfunction

    // Reference: byte-addressed little-endian memory, access rules applied directly
    function automatic void ref_access(input logic w, input logic [1:0] sz, input logic sg,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       output logic er, output logic [31:0] rd,
                                       output int lat);
        int nb;
        logic [31:0] v;
        nb = 1 << sz;
        er = (sz == 2'd3) || (!SUB && sz != 2'd2) || ((a % 32'(nb)) != 32'd0) ||
             (a >= MEM_BYTES);
        rd = 32'd0;
        if (er) begin
            lat = 1;
        end else if (w) begin
            for (int i = 0; i < nb; i++) shadow[int'(a) + i] = wd[8*i +: 8];
            lat = (nb == 4) ? 2 : 3;
        end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v = v | (32'(shadow[int'(a) + i]) << (8 * i));
            if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            rd  = v;
            lat = 2;
        end
    endfunction

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic strobed);
        int   guard;
        logic overlap;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("ready_wait", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat       = 1;
        strobed   = readenable | writeenable;
        overlap   = readenable & writeenable;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
            strobed = strobed | readenable | writeenable;
            overlap = overlap | (readenable & writeenable);
        end
        rd = rsp_rdata;
        er = rsp_error;
        check("strobe_overlap", 32'(overlap), 32'd0);
        @(posedge clk);
        #1;
        check("rsp_single_pulse", 32'(rsp_valid), 32'd0);
    endtask

    typedef struct {
        string       name;
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    initial begin
        logic [31:0] rd, m_rd, a, wd;
        logic        er, m_er, strobed, w, sg;
        logic [1:0]  sz;
        int          lat, m_lat, pick, pulses;

        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= 32'd0;
        for (int i = 0; i < int'(MEM_BYTES); i++) shadow[i] = 8'd0;
        outdata <= 32'd0;

        vecs[0]  = '{"st_w_10",   1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0, 2};
        vecs[1]  = '{"ld_w_10",   1'b0, 2'd2, 1'b0, 32'h10,  32'h0, 1'b0, 32'hDEADBEEF, 2};
        vecs[2]  = '{"st_w_20",   1'b1, 2'd2, 1'b0, 32'h20,  32'h11223344, 1'b0, 32'h0, 2};
        vecs[3]  = '{"st_b_21",   1'b1, 2'd0, 1'b0, 32'h21,  32'h000000AB, !SUB, 32'h0,
                     SUB ? 3 : 1};
        vecs[4]  = '{"ld_w_20",   1'b0, 2'd2, 1'b0, 32'h20,  32'h0, 1'b0,
                     SUB ? 32'h1122AB44 : 32'h11223344, 2};
        vecs[5]  = '{"ld_bs_21",  1'b0, 2'd0, 1'b1, 32'h21,  32'h0, !SUB,
                     SUB ? 32'hFFFFFFAB : 32'h0, SUB ? 2 : 1};
        vecs[6]  = '{"ld_bu_21",  1'b0, 2'd0, 1'b0, 32'h21,  32'h0, !SUB,
                     SUB ? 32'h000000AB : 32'h0, SUB ? 2 : 1};
        vecs[7]  = '{"st_w_20b",  1'b1, 2'd2, 1'b0, 32'h20,  32'h80001234, 1'b0, 32'h0, 2};
        vecs[8]  = '{"ld_hs_22",  1'b0, 2'd1, 1'b1, 32'h22,  32'h0, !SUB,
                     SUB ? 32'hFFFF8000 : 32'h0, SUB ? 2 : 1};
        vecs[9]  = '{"ld_hu_22",  1'b0, 2'd1, 1'b0, 32'h22,  32'h0, !SUB,
                     SUB ? 32'h00008000 : 32'h0, SUB ? 2 : 1};
        vecs[10] = '{"ld_w_13",   1'b0, 2'd2, 1'b0, 32'h13,  32'h0, 1'b1, 32'h0, 1};
        vecs[11] = '{"ld_w_400",  1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, 1};
        vecs[12] = '{"ld_h_21",   1'b0, 2'd1, 1'b0, 32'h21,  32'h0, 1'b1, 32'h0, 1};
        vecs[13] = '{"ld_rsvd",   1'b0, 2'd3, 1'b0, 32'h20,  32'h0, 1'b1, 32'h0, 1};
        vecs[14] = '{"st_w_3fc",  1'b1, 2'd2, 1'b0, 32'h3FC, 32'hCAFEF00D, 1'b0, 32'h0, 2};
        vecs[15] = '{"ld_w_3fc",  1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'hCAFEF00D, 2};
        vecs[16] = '{"st_w_400",  1'b1, 2'd2, 1'b0, 32'h400, 32'h12345678, 1'b1, 32'h0, 1};
        vecs[17] = '{"ld_w_0",    1'b0, 2'd2, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0, 2};
        vecs[18] = '{"st_h_22",   1'b1, 2'd1, 1'b0, 32'h22,  32'h00005A5A, !SUB, 32'h0,
                     SUB ? 3 : 1};
        vecs[19] = '{"ld_w_20c",  1'b0, 2'd2, 1'b0, 32'h20,  32'h0, 1'b0,
                     SUB ? 32'h5A5A1234 : 32'h80001234, 2};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;

        #12;
        check("rst_req_ready",   32'(req_ready), 32'd1);
        check("rst_rsp_valid",   32'(rsp_valid), 32'd0);
        check("rst_rsp_error",   32'(rsp_error), 32'd0);
        check("rst_rsp_rdata",   rsp_rdata, 32'd0);
        check("rst_readenable",  32'(readenable), 32'd0);
        check("rst_writeenable", 32'(writeenable), 32'd0);
        check("rst_address",     Address, 32'd0);
        check("rst_writedata",   writedata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Directed vectors
        for (int i = 0; i < NVEC; i++) begin
            do_req(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd,
                   rd, er, lat, strobed);
            ref_access(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd,
                       m_er, m_rd, m_lat);
            check($sformatf("%s.rdata", vecs[i].name), rd, vecs[i].exp_rd);
            check($sformatf("%s.error", vecs[i].name), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("%s.latency", vecs[i].name), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("%s.strobed", vecs[i].name), 32'(strobed),
                  32'(!vecs[i].exp_err));
            check($sformatf("%s.address", vecs[i].name), Address,
                  (vecs[i].a >> 2) & 32'hFF);
            check($sformatf("%s.hold_rdata", vecs[i].name), rsp_rdata, vecs[i].exp_rd);
            check($sformatf("%s.hold_error", vecs[i].name), 32'(rsp_error),
                  32'(vecs[i].exp_err));
        end

        // A request held valid while busy must not be taken again
        pulses = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h10;
        @(posedge clk);
        #1;
        req_addr  = 32'h20;
        req_write = 1'b1;
        req_wdata = 32'hFFFF_FFFF;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        req_valid = 1'b0;
        check("busy.latency", 32'(lat), 32'd2);
        check("busy.rdata", rsp_rdata, 32'hDEADBEEF);
        check("busy.address", Address, 32'd4);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) pulses++;
        end
        check("busy.no_extra_rsp", 32'(pulses), 32'd0);
        check("busy.mem_untouched", mem[8], shadow_word(8));

        // Reset during the WR cycle of a word store drops the write
        pulses = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h30;
        req_wdata = 32'h55AA55AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rst_wr.we_high", 32'(writeenable), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_wr.we_drop", 32'(writeenable), 32'd0);
        check("rst_wr.re_low", 32'(readenable), 32'd0);
        check("rst_wr.rsp_low", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_wr.ready", 32'(req_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) pulses++;
        end
        check("rst_wr.no_rsp", 32'(pulses), 32'd0);
        check("rst_wr.mem_unchanged", mem[12], shadow_word(12));
        do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, er, lat, strobed);
        check("rst_wr.reload", rd, shadow_word(12));

        // Randomized traffic against the reference
        for (int n = 0; n < 300; n++) begin
            w    = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            sg   = 1'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 15));
            if (pick == 0) a = $urandom;
            else if (pick == 1) a = MEM_BYTES - 32'd4 + 32'($urandom_range(0, 7));
            else a = 32'($urandom_range(0, 95));
            wd = $urandom;
            ref_access(w, sz, sg, a, wd, m_er, m_rd, m_lat);
            do_req(w, sz, sg, a, wd, rd, er, lat, strobed);
            check($sformatf("rnd%0d.rdata a=%h sz=%0d", n, a, sz), rd, m_rd);
            check($sformatf("rnd%0d.error", n), 32'(er), 32'(m_er));
            check($sformatf("rnd%0d.latency", n), 32'(lat), 32'(m_lat));
            check($sformatf("rnd%0d.strobed", n), 32'(strobed), 32'(!m_er));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        #1;
        for (int i = 0; i < 24; i++) begin
            check($sformatf("final_mem[%0d]", i), mem[i], shadow_word(i));
        end
        check("final_mem_top", mem[MEM_WORDS-1], shadow_word(int'(MEM_WORDS) - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_AW, default 8, word-address width of the attached data memory (256 words).
REQ-002 Port: clk  input  1  single clock; all state updates on posedge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req_valid  input  1  CPU request present.
REQ-005 Port: req_ready  output  1  unit can accept a request.
REQ-006 Port: req_write  input  1  1 = store, 0 = load.
REQ-007 Port: req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved (error).
REQ-008 Port: req_signed  input  1  sign-extend subword loads.
REQ-009 Port: req_addr  input  32  byte address.
REQ-010 Port: req_wdata  input  32  store data, right-aligned.
REQ-011 Port: rsp_valid  output  1  one-cycle completion pulse.
REQ-012 Port: rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-013 Port: rsp_error  output  1  misaligned, out-of-range or reserved-size request.
REQ-014 Port: Address  output  32  word index to data memory: {0, req_addr[MEM_AW+1:2]}.
REQ-015 Port: writeenable  output  1  memory write strobe, sampled by memory on posedge.
REQ-016 Port: readenable  output  1  memory read strobe; memory updates outdata on negedge.
REQ-017 Port: writedata  output  32  memory write word.
REQ-018 Port: outdata  input  32  memory read word.

Function
REQ-019 The unit SHALL accept a request on a posedge where req_valid && req_ready, latching all req_* fields; req_ready SHALL be 1 only in IDLE.
REQ-020 The FSM SHALL have states IDLE, RD, WR, RESP.
REQ-021 Transitions: IDLE->RD on a load or a subword store; IDLE->WR on a word store; IDLE->RESP on an error; RD->RESP (load) or RD->WR (subword store); WR->RESP; RESP->IDLE.
REQ-022 All memory-side outputs SHALL be registered: readenable = 1 only in RD; writeenable = 1 only in WR; the two SHALL never be high together.
REQ-023 In RD, the unit SHALL sample outdata on the posedge that leaves RD (data is valid after the intervening negedge).
REQ-024 Latency from acceptance edge to rsp_valid: load 2 cycles, word store 2 cycles, subword store 3 cycles, error 1 cycle.
REQ-025 Subword store SHALL be a read-modify-write: the sampled word has only the addressed byte or half replaced by req_wdata[7:0] or [15:0], selected by addr[1:0] (little-endian).
REQ-026 Subword load SHALL extract the addressed lane and then zero-extend, or sign-extend when req_signed = 1.
REQ-027 Error conditions: half with addr[0] = 1; word with addr[1:0] != 0; req_size = 11; or any set bit in req_addr[31:MEM_AW+2].
REQ-028 On an error the unit SHALL assert neither memory strobe, SHALL pulse rsp_valid with rsp_error = 1 and rsp_rdata = 0, and SHALL leave memory unchanged.
REQ-029 rsp_valid SHALL be high for exactly one cycle, in RESP; rsp_rdata and rsp_error SHALL hold their values until the next RESP.
REQ-030 A req_valid presented while busy SHALL be ignored (not queued); the CPU SHALL hold it until req_ready.

Reset
REQ-031 On reset the unit SHALL enter IDLE immediately, independent of clk.
REQ-032 Reset values: req_ready = 1 after release; rsp_valid = 0, rsp_error = 0, rsp_rdata = 0, readenable = 0, writeenable = 0, Address = 0, writedata = 0.
REQ-033 A reset asserted mid-operation SHALL abort the operation; a write whose strobe has not been sampled SHALL be dropped, and no response SHALL be issued.

Configuration
REQ-034 Macro LSU_SUBWORD_EN: when defined, byte and half operations SHALL behave per REQ-025/026.
REQ-035 When LSU_SUBWORD_EN is undefined, req_size 00 or 01 SHALL be treated as an error per REQ-028, and RD SHALL never transition to WR.

Verification
REQ-036 Word store 0xDEADBEEF to addr 0x10, then word load from 0x10 -> rsp_rdata = 0xDEADBEEF, Address = 4, load rsp_valid 2 cycles after acceptance.
REQ-037 (SUBWORD_EN) Word 0x11223344 at 0x20; byte store 0xAB to 0x21 -> memory word 0x1122AB44; signed byte load from 0x21 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
REQ-038 Half load from 0x22 with req_signed = 1 on word 0x80001234 -> 0xFFFF8000.
REQ-039 Word load from 0x13, and word load from 0x400 -> rsp_error = 1 and rsp_rdata = 0 after 1 cycle; readenable and writeenable remain 0.
REQ-040 Assert reset in the WR cycle of a store -> writeenable drops immediately, the target word is unchanged, no rsp_valid, and req_ready = 1 after release.
